// File: rtl/mem_arbiter_fsm.sv
// Fixed-priority arbiter sharing one pipelined memory between the D-cache and I-cache miss paths.
// Optional starvation guard for the I side is built only when STARVE_GUARD_EN is defined.
module mem_arbiter_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          d_req,
  input  logic                          d_wr,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [15:0]                   d_wdata,
  input  logic                          i_req,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  output logic [15:0]                   d_rdata,
  output logic [15:0]                   i_rdata,
  output logic                          d_rvalid,
  output logic                          i_rvalid,
  output logic [$clog2(BURST_LEN)-1:0]  d_widx,
  output logic [$clog2(BURST_LEN)-1:0]  i_widx,
  output logic                          d_done,
  output logic                          i_done,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [15:0]                   mem_wdata,
  input  logic [15:0]                   mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          freeze,
  output logic                          busy
);
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, D_RD, I_RD, D_WR} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        iss_cnt_q;
  logic [CNT_W-1:0]        ret_cnt_q;
  logic [LAT_W-1:0]        wait_cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    mem_en_q;
  logic                    mem_wr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [15:0]             mem_wdata_q;

  logic                    rd_state;
  logic                    ret_ok;
  logic                    last_ret;
  logic                    wr_done;
  logic                    starve_hit;
  logic                    grant_i;
  logic                    grant_d_rd;
  logic                    grant_d_wr;
  logic [ADDR_WIDTH-1:0]   line_base;

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
`endif

  always_comb begin
    rd_state   = (state_q == D_RD) || (state_q == I_RD);
    // A return is only accepted for a word that has already been issued.
    ret_ok     = rd_state && mem_rvalid && (ret_cnt_q < iss_cnt_q);
    last_ret   = ret_ok && (ret_cnt_q == CNT_W'(BURST_LEN - 1));
    wr_done    = (state_q == D_WR) && (wait_cnt_q == LAT_W'(MEM_LAT));
`ifdef STARVE_GUARD_EN
    starve_hit = i_req && (starve_q >= SW'(STARVE_MAX));
`else
    starve_hit = 1'b0;
`endif
    grant_i    = i_req && (starve_hit || !(d_req && !d_wr));
    grant_d_rd = d_req && !d_wr && !grant_i;
    grant_d_wr = d_req && d_wr && !i_req;
    line_base  = (grant_i ? i_addr : d_addr) & LINE_MASK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      iss_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      base_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          iss_cnt_q  <= '0;
          ret_cnt_q  <= '0;
          wait_cnt_q <= '0;
          mem_en_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
          if (grant_i || grant_d_rd) begin
            state_q    <= grant_i ? I_RD : D_RD;
            base_q     <= line_base;
            mem_en_q   <= 1'b1;
            mem_addr_q <= line_base;
            iss_cnt_q  <= CNT_W'(1);
          end else if (grant_d_wr) begin
            state_q     <= D_WR;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end
`ifdef STARVE_GUARD_EN
          if (grant_i || !i_req) starve_q <= '0;
          else if (grant_d_rd)   starve_q <= starve_q + SW'(1);
`endif
        end
        D_RD, I_RD: begin
          if (iss_cnt_q < CNT_W'(BURST_LEN)) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= base_q + ADDR_WIDTH'(iss_cnt_q);
            iss_cnt_q  <= iss_cnt_q + CNT_W'(1);
          end else begin
            mem_en_q   <= 1'b0;
          end
          if (ret_ok)   ret_cnt_q <= ret_cnt_q + CNT_W'(1);
          if (last_ret) state_q   <= IDLE;
        end
        D_WR: begin
          mem_en_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
          wait_cnt_q <= wait_cnt_q + LAT_W'(1);
          if (wr_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Returned data and freeze are forced low while reset is held.
  assign d_rdata   = mem_rdata & {16{rst}};
  assign i_rdata   = mem_rdata & {16{rst}};
  assign d_rvalid  = ret_ok && (state_q == D_RD);
  assign i_rvalid  = ret_ok && (state_q == I_RD);
  assign d_widx    = ret_cnt_q[IDX_W-1:0];
  assign i_widx    = ret_cnt_q[IDX_W-1:0];
  assign d_done    = ((state_q == D_RD) && last_ret) || wr_done;
  assign i_done    = (state_q == I_RD) && last_ret;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign freeze    = rst && (d_req || i_req);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Bench for mem_arbiter_fsm: directed vector table, reset/starvation sequences and a
// randomized run scored against a cycle-offset model of the arbitration rules.
module tb_mem_arbiter_fsm;
  localparam int AW   = 16;
  localparam int BL   = 4;
  localparam int LAT  = 4;
  localparam int SMAX = 3;
  localparam logic [AW-1:0] LM = ~AW'(BL - 1);
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_req, d_wr, i_req, mem_rvalid;
  logic [AW-1:0] d_addr, i_addr, mem_addr;
  logic [15:0] d_wdata, mem_rdata, d_rdata, i_rdata, mem_wdata;
  logic d_rvalid, i_rvalid, d_done, i_done, mem_en, mem_wr, freeze, busy;
  logic [1:0] d_widx, i_widx;

  always #5 clk = ~clk;

  mem_arbiter_fsm #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_req(i_req), .i_addr(i_addr),
    .d_rdata(d_rdata), .i_rdata(i_rdata), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
    .d_widx(d_widx), .i_widx(i_widx), .d_done(d_done), .i_done(i_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .freeze(freeze), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = -1;
  logic stray_en = 1'b0;

  typedef struct { int due; logic [AW-1:0] addr; } ret_t;
  ret_t mq[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic d_req; logic d_wr; logic [AW-1:0] d_addr; logic [15:0] d_wdata;
    logic i_req; logic [AW-1:0] i_addr;
    int exp_dd; int exp_id; logic [AW-1:0] exp_addr1; logic exp_wr1; logic [15:0] exp_wd1;
    int exp_drc; int exp_irc;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [15:0] mdata(input logic [AW-1:0] a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory model: returns each read MEM_LAT cycles after its issue cycle, plus optional strays.
  task automatic tick();
    ret_t r;
    @(posedge clk); #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    while (mq.size() > 0 && mq[0].due < cyc) r = mq.pop_front();
    if (mq.size() > 0 && mq[0].due == cyc) begin
      r = mq.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mdata(r.addr);
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1'b1;
    end
  endtask

  task automatic sample_mem();
    if (mem_en && !mem_wr) mq.push_back('{cyc + LAT, mem_addr});
  endtask

  task automatic apply_reset();
    rst = 1'b0; d_req = 0; d_wr = 0; i_req = 0; d_addr = '0; i_addr = '0;
    d_wdata = '0; mem_rvalid = 0; mem_rdata = '0; stray_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mq.delete();
    exp_q.delete();
    cyc = -1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int dd, id, drc, irc;
    logic dh, ih;
    apply_reset();
    dd = -1; id = -1; drc = 0; irc = 0; dh = v.d_req; ih = v.i_req;
    for (int c = 0; c < 30; c++) begin
      tick();
      d_req = dh; d_wr = v.d_wr; d_addr = v.d_addr; d_wdata = v.d_wdata;
      i_req = ih; i_addr = v.i_addr;
      @(negedge clk);
      sample_mem();
      check("v_freeze", freeze, d_req | i_req);
      if (cyc == 1) begin
        check("v_mem_en1", mem_en, 1);
        check("v_mem_wr1", mem_wr, v.exp_wr1);
        check("v_mem_addr1", mem_addr, v.exp_addr1);
        if (v.exp_wr1) check("v_mem_wdata1", mem_wdata, v.exp_wd1);
      end
      if (d_rvalid) begin
        check("v_d_widx", d_widx, drc);
        check("v_d_rdata", d_rdata, mdata((v.d_addr & LM) + AW'(drc)));
        drc++;
      end
      if (i_rvalid) begin
        check("v_i_widx", i_widx, irc);
        check("v_i_rdata", i_rdata, mdata((v.i_addr & LM) + AW'(irc)));
        irc++;
      end
      if (d_done) begin dd = cyc; dh = 1'b0; end
      if (i_done) begin id = cyc; ih = 1'b0; end
    end
    $display("[TB] vector %0d: d_done@%0d i_done@%0d", idx, dd, id);
    check("v_d_done_cyc", dd, v.exp_dd);
    check("v_i_done_cyc", id, v.exp_id);
    check("v_d_rv_count", drc, v.exp_drc);
    check("v_i_rv_count", irc, v.exp_irc);
    check("v_busy_end", busy, 0);
  endtask

  task automatic reset_mid_burst();
    int bad;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      i_req = 1'b1; i_addr = 16'h0030;
      if (cyc == 3) break;
      @(negedge clk);
      sample_mem();
    end
    #1 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_freeze", freeze, 0);
    check("rst_rdata", {d_rdata, i_rdata}, 0);
    check("rst_rvalid_done", {d_rvalid, i_rvalid, d_done, i_done}, 0);
    check("rst_widx", {d_widx, i_widx}, 0);
    i_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    stray_en = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (d_rvalid || i_rvalid || d_done || i_done || busy) bad++;
    end
    stray_en = 1'b0;
    check("rst_no_activity", bad, 0);
  endtask

  task automatic starve_seq();
    int order[$];
    int exp_order[5];
    int dcnt;
    logic dh, ih;
    apply_reset();
    dh = 1; ih = 1; dcnt = 0;
    if (GUARD) exp_order = '{0, 0, 0, 1, 0};
    else       exp_order = '{0, 0, 0, 0, 1};
    for (int c = 0; c < 150 && (dh || ih); c++) begin
      tick();
      d_req = dh; d_wr = 1'b0; d_addr = AW'(16'h0040 * (dcnt + 1));
      i_req = ih; i_addr = 16'h0200;
      @(negedge clk);
      sample_mem();
      check("st_freeze", freeze, d_req | i_req);
      if (d_done) begin
        order.push_back(0); dcnt++;
        if (dcnt == 4) dh = 1'b0;
      end
      if (i_done) begin order.push_back(1); ih = 1'b0; end
    end
    check("st_count", order.size(), 5);
    for (int k = 0; k < 5; k++)
      check("st_order", (k < order.size()) ? order[k] : -1, exp_order[k]);
  endtask

  // Randomized run: expected behaviour from grant cycle + offset arithmetic.
  logic m_busy, m_i, m_wr;
  int m_start, m_starve;
  logic [AW-1:0] m_base;
  logic [15:0] m_wdata;
  logic d_act, i_act, d_gnt, i_gnt, d_drop, i_drop, d_cool, i_cool;
  logic dwr_v;
  logic [AW-1:0] daddr_v, iaddr_v;
  logic [15:0] dwd_v;

  task automatic random_run(input int n_cycles);
    int k, widx;
    logic e_en, e_wr, e_rv, e_done, hit;
    logic [AW-1:0] e_addr;
    logic [15:0] e_wd, w;
    apply_reset();
    m_busy = 0; m_i = 0; m_wr = 0; m_start = 0; m_starve = 0; m_base = '0; m_wdata = '0;
    d_act = 0; i_act = 0; d_gnt = 0; i_gnt = 0; d_drop = 0; i_drop = 0; d_cool = 0; i_cool = 0;
    dwr_v = 0; daddr_v = '0; iaddr_v = '0; dwd_v = '0;
    for (int n = 0; n < n_cycles; n++) begin
      stray_en = !(m_busy && !m_wr);
      tick();
      if (!d_act && !d_cool && $urandom_range(0, 3) == 0) begin
        d_act = 1; dwr_v = 1'($urandom_range(0, 1)); daddr_v = AW'($urandom); dwd_v = 16'($urandom);
      end
      if (!i_act && !i_cool && $urandom_range(0, 3) == 0) begin
        i_act = 1; iaddr_v = AW'($urandom);
      end
      if (d_gnt && $urandom_range(0, 7) == 0) d_drop = 1;
      if (i_gnt && $urandom_range(0, 7) == 0) i_drop = 1;
      d_cool = 0; i_cool = 0;
      d_req = d_act && !d_drop; d_wr = dwr_v; d_addr = daddr_v; d_wdata = dwd_v;
      i_req = i_act && !i_drop; i_addr = iaddr_v;
      @(negedge clk);
      sample_mem();
      e_en = 0; e_wr = 0; e_rv = 0; e_done = 0; e_addr = '0; e_wd = '0; widx = 0;
      if (m_busy) begin
        k = cyc - m_start;
        if (!m_wr) begin
          e_en = (k < BL); e_addr = m_base + AW'(k);
          if (k >= LAT && k < LAT + BL) begin e_rv = 1; widx = k - LAT; end
          e_done = (k == LAT + BL - 1);
        end else begin
          e_en = (k == 0); e_wr = 1; e_addr = m_base; e_wd = m_wdata;
          e_done = (k == LAT);
        end
      end
      check("r_busy", busy, m_busy);
      check("r_mem_en", mem_en, e_en);
      if (e_en) begin
        check("r_mem_wr", mem_wr, e_wr);
        check("r_mem_addr", mem_addr, e_addr);
        if (e_wr) check("r_mem_wdata", mem_wdata, e_wd);
      end
      check("r_d_rvalid", d_rvalid, e_rv && !m_i);
      check("r_i_rvalid", i_rvalid, e_rv && m_i);
      check("r_d_done", d_done, e_done && !m_i);
      check("r_i_done", i_done, e_done && m_i);
      check("r_freeze", freeze, d_req | i_req);
      check("r_rdata_mirror", {d_rdata, i_rdata}, {mem_rdata, mem_rdata});
      if (e_rv) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        check("r_widx", m_i ? i_widx : d_widx, widx);
        check("r_rdata", m_i ? i_rdata : d_rdata, w);
      end
      if (m_busy) begin
        if (e_done) begin
          m_busy = 0;
          if (m_i) begin i_act = 0; i_gnt = 0; i_drop = 0; i_cool = 1; end
          else     begin d_act = 0; d_gnt = 0; d_drop = 0; d_cool = 1; end
        end
      end else begin
        hit = GUARD && i_req && (m_starve >= SMAX);
        if (d_req && !d_wr && !hit) begin
          m_busy = 1; m_i = 0; m_wr = 0; m_base = d_addr & LM; d_gnt = 1;
        end else if (i_req) begin
          m_busy = 1; m_i = 1; m_wr = 0; m_base = i_addr & LM; i_gnt = 1;
        end else if (d_req) begin
          m_busy = 1; m_i = 0; m_wr = 1; m_base = d_addr; m_wdata = d_wdata; d_gnt = 1;
        end
        if (!i_req || (m_busy && m_i)) m_starve = 0;
        else if (m_busy) m_starve++;
        if (m_busy) begin
          m_start = cyc + 1;
          if (!m_wr) for (int j = 0; j < BL; j++) exp_q.push_back(mdata(m_base + AW'(j)));
        end
      end
    end
    stray_en = 0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0013,  -1,  8, 16'h0010, 1'b0, 16'h0000, 0, 4};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000,   5, -1, 16'h0100, 1'b1, 16'hBEEF, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0080,   8, 17, 16'h0040, 1'b0, 16'h0000, 4, 4};
    vecs[3] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h0000,   8, -1, 16'h00FC, 1'b0, 16'h0000, 4, 0};
    vecs[4] = '{1'b1, 1'b1, 16'h0123, 16'h1234, 1'b1, 16'h0021,  14,  8, 16'h0020, 1'b0, 16'h0000, 0, 4};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000,   5, -1, 16'hFFFF, 1'b1, 16'h0001, 0, 0};

    d_req = 1; d_wr = 0; i_req = 1; d_addr = 16'h1234; i_addr = 16'h4321;
    d_wdata = 16'hFFFF; mem_rvalid = 1; mem_rdata = 16'hA5A5;
    #3;
    check("init_busy", busy, 0);
    check("init_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
    check("init_out", {d_rvalid, i_rvalid, d_done, i_done, freeze}, 0);
    check("init_rdata", {d_rdata, i_rdata}, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    reset_mid_burst();
    starve_seq();
    random_run(2500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
